// File: rtl/key_pwm_ctrl.sv
// Key event decoder with hold-to-auto-repeat duty control and a glitch-free PWM generator.
// Duty changes are picked up by the PWM only at a period boundary.
module key_pwm_ctrl #(
    parameter int DW         = 16,
    parameter int PERIOD     = 1000,
    parameter int STEP       = 50,
    parameter int DUTY_INIT  = 500,
    parameter int HOLD_CYC   = 25_000_000,
    parameter int REPEAT_CYC = 5_000_000
) (
    input  logic          clk,
    input  logic          n_reset,
    input  logic [3:0]    press,
    output logic [3:0]    key_evt,
    output logic [DW-1:0] duty,
    output logic          enable,
    output logic          pwm_out
);

    localparam int TMAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYC - 1);
    localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYC - 1);
    localparam logic [DW-1:0] PERIOD_W  = DW'(PERIOD);
    localparam logic [DW-1:0] INIT_W    = DW'(DUTY_INIT);
    localparam logic [DW-1:0] CNT_LAST  = DW'(PERIOD - 1);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

    function automatic logic [DW-1:0] step_up(input logic [DW-1:0] d);
        logic [DW:0] s;
        s = {1'b0, d} + (DW+1)'(STEP);
        return (s > {1'b0, PERIOD_W}) ? PERIOD_W : s[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] step_down(input logic [DW-1:0] d);
        return ({1'b0, d} < (DW+1)'(STEP)) ? '0 : d - DW'(STEP);
    endfunction

    function automatic logic [DW-1:0] apply_step(input logic [DW-1:0] d, input logic dn);
        return dn ? step_down(d) : step_up(d);
    endfunction

    logic [3:0]    press_q;
    logic [3:0]    key_evt_q, key_evt_d;
    logic [DW-1:0] duty_q, duty_d;
    logic          enable_q, enable_d;
    logic          pwm_q, pwm_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] duty_act_q, duty_act_d;
    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          dir_q, dir_d;

    logic [3:0] rise;
    logic       act;
    logic       cur_dn;
    logic       cur_rise;

    always_comb begin
        rise     = press & ~press_q;
        act      = press[0] ^ press[1];
        cur_dn   = press[1];
        cur_rise = cur_dn ? rise[1] : rise[0];

        key_evt_d = rise;
        enable_d  = enable_q ^ rise[2];
        duty_d    = duty_q;
        state_d   = state_q;
        timer_d   = timer_q;
        dir_d     = dir_q;

        if (rise[3]) begin
            duty_d  = INIT_W;
            state_d = IDLE;
            timer_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (act && cur_rise) begin
                        duty_d  = apply_step(duty_q, cur_dn);
                        dir_d   = cur_dn;
                        timer_d = '0;
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    // A release or a switch to the other key ends the run without a step.
                    if (!act || (cur_dn != dir_q)) begin
                        state_d = IDLE;
                    end else if (timer_q == HOLD_LAST) begin
                        duty_d  = apply_step(duty_q, dir_q);
                        timer_d = '0;
                        state_d = REPEAT;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                REPEAT: begin
                    if (!act || (cur_dn != dir_q)) begin
                        state_d = IDLE;
                    end else if (timer_q == REP_LAST) begin
                        duty_d  = apply_step(duty_q, dir_q);
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        cnt_d      = (cnt_q == CNT_LAST) ? '0 : cnt_q + DW'(1);
        duty_act_d = (cnt_q == CNT_LAST) ? duty_q : duty_act_q;
        pwm_d      = enable_q & (cnt_q < duty_act_q);
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            press_q    <= '0;
            key_evt_q  <= '0;
            duty_q     <= INIT_W;
            enable_q   <= 1'b1;
            pwm_q      <= 1'b0;
            cnt_q      <= '0;
            duty_act_q <= INIT_W;
            state_q    <= IDLE;
            timer_q    <= '0;
            dir_q      <= 1'b0;
        end else begin
            press_q    <= press;
            key_evt_q  <= key_evt_d;
            duty_q     <= duty_d;
            enable_q   <= enable_d;
            pwm_q      <= pwm_d;
            cnt_q      <= cnt_d;
            duty_act_q <= duty_act_d;
            state_q    <= state_d;
            timer_q    <= timer_d;
            dir_q      <= dir_d;
        end
    end

    assign key_evt = key_evt_q;
    assign duty    = duty_q;
    assign enable  = enable_q;
    assign pwm_out = pwm_q;

endmodule

// File: tb/tb_key_pwm_ctrl.sv
// Bench for key_pwm_ctrl: directed vector table, an async-reset-during-repeat sequence,
// and randomized key activity compared each cycle against a behavioural model.
module tb_key_pwm_ctrl;

    localparam int DW         = 8;
    localparam int PERIOD     = 10;
    localparam int STEP       = 3;
    localparam int DUTY_INIT  = 5;
    localparam int HOLD_CYC   = 20;
    localparam int REPEAT_CYC = 5;

    logic          clk = 1'b0;
    logic          n_reset;
    logic [3:0]    press;
    logic [3:0]    key_evt;
    logic [DW-1:0] duty;
    logic          enable;
    logic          pwm_out;

    int checks   = 0;
    int failures = 0;

    key_pwm_ctrl #(
        .DW(DW), .PERIOD(PERIOD), .STEP(STEP), .DUTY_INIT(DUTY_INIT),
        .HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC)
    ) dut (
        .clk(clk), .n_reset(n_reset), .press(press),
        .key_evt(key_evt), .duty(duty), .enable(enable), .pwm_out(pwm_out)
    );

    always #5 clk = ~clk;

    // Behavioural model: a held key is a "run" with an age in cycles since its first step;
    // steps fall at age 0, age HOLD_CYC, then every REPEAT_CYC after that.
    int         m_duty, m_cnt, m_dact;
    bit         m_en, m_pwm;
    logic [3:0] m_evt, m_pp;
    bit         run_on;
    int         run_dir, run_age;

    function automatic int do_step(input int d, input int dn);
        if (dn != 0) return (d < STEP) ? 0 : d - STEP;
        return (d + STEP > PERIOD) ? PERIOD : d + STEP;
    endfunction

    task automatic model_reset();
        m_duty = DUTY_INIT; m_en = 1'b1; m_pwm = 1'b0; m_evt = '0;
        m_cnt = 0; m_dact = DUTY_INIT; m_pp = '0;
        run_on = 1'b0; run_dir = 0; run_age = 0;
    endtask

    task automatic model_clock(input logic [3:0] p);
        logic [3:0] rise;
        bit act, was_on;
        int k, nd;
        rise   = p & ~m_pp;
        act    = p[0] ^ p[1];
        k      = p[1] ? 1 : 0;
        nd     = m_duty;
        if (rise[3]) begin
            nd     = DUTY_INIT;
            run_on = 1'b0;
        end else begin
            was_on = run_on;
            if (run_on) begin
                if (!act || k != run_dir) run_on = 1'b0;
                else begin
                    run_age++;
                    if (run_age == HOLD_CYC ||
                        (run_age > HOLD_CYC && (run_age - HOLD_CYC) % REPEAT_CYC == 0))
                        nd = do_step(m_duty, run_dir);
                end
            end
            if (!was_on && act && rise[k]) begin
                nd      = do_step(m_duty, k);
                run_on  = 1'b1;
                run_dir = k;
                run_age = 0;
            end
        end
        m_pwm  = m_en && (m_cnt < m_dact);
        m_dact = (m_cnt == PERIOD - 1) ? m_duty : m_dact;
        m_cnt  = (m_cnt + 1) % PERIOD;
        m_en   = m_en ^ rise[2];
        m_evt  = rise;
        m_duty = nd;
        m_pp   = p;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cmp_model();
        chk("model_key_evt", 32'(key_evt), 32'(m_evt));
        chk("model_duty",    32'(duty),    32'(m_duty));
        chk("model_enable",  32'(enable),  32'(m_en));
        chk("model_pwm_out", 32'(pwm_out), 32'(m_pwm));
    endtask

    task automatic cyc(input logic [3:0] p);
        @(negedge clk);
        press = p;
        @(posedge clk);
        model_clock(p);
        #1;
        cmp_model();
    endtask

    typedef struct {
        logic [3:0] press;
        int         cycles;
        int         exp_duty;
        bit         exp_en;
    } vec_t;

    vec_t vecs[24];

    initial begin
        vecs[0]  = '{4'b0000, 12,  5, 1'b1};
        vecs[1]  = '{4'b0001,  3,  8, 1'b1};
        vecs[2]  = '{4'b0000,  2,  8, 1'b1};
        vecs[3]  = '{4'b0010,  1,  5, 1'b1};
        vecs[4]  = '{4'b0000,  1,  5, 1'b1};
        vecs[5]  = '{4'b0010,  1,  2, 1'b1};
        vecs[6]  = '{4'b0000, 12,  2, 1'b1};
        vecs[7]  = '{4'b0010,  1,  0, 1'b1};
        vecs[8]  = '{4'b0000, 12,  0, 1'b1};
        vecs[9]  = '{4'b0010,  1,  0, 1'b1};
        vecs[10] = '{4'b0000,  1,  0, 1'b1};
        vecs[11] = '{4'b0011,  1,  0, 1'b1};
        vecs[12] = '{4'b0000,  1,  0, 1'b1};
        vecs[13] = '{4'b1000,  1,  5, 1'b1};
        vecs[14] = '{4'b0000,  1,  5, 1'b1};
        vecs[15] = '{4'b0100,  1,  5, 1'b0};
        vecs[16] = '{4'b0000, 12,  5, 1'b0};
        vecs[17] = '{4'b0100,  1,  5, 1'b1};
        vecs[18] = '{4'b0000,  1,  5, 1'b1};
        vecs[19] = '{4'b0001, 60, 10, 1'b1};
        vecs[20] = '{4'b0010,  3, 10, 1'b1};
        vecs[21] = '{4'b0000,  1, 10, 1'b1};
        vecs[22] = '{4'b0010,  1,  7, 1'b1};
        vecs[23] = '{4'b0000,  1,  7, 1'b1};

        n_reset = 1'b0;
        press   = 4'b0000;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_duty",    32'(duty),    32'(DUTY_INIT));
        chk("reset_enable",  32'(enable),  32'd1);
        chk("reset_pwm_out", 32'(pwm_out), 32'd0);
        chk("reset_key_evt", 32'(key_evt), 32'd0);
        @(posedge clk);
        #2 n_reset = 1'b1;

        for (int i = 0; i < 24; i++) begin
            for (int c = 0; c < vecs[i].cycles; c++) cyc(vecs[i].press);
            chk($sformatf("vec%0d_duty", i),   32'(duty),   32'(vecs[i].exp_duty));
            chk($sformatf("vec%0d_enable", i), 32'(enable), 32'(vecs[i].exp_en));
        end

        // Walk duty down to 0, then hold up into REPEAT until duty reaches 9.
        for (int i = 0; i < 3; i++) begin
            cyc(4'b0010);
            cyc(4'b0000);
        end
        chk("floor_duty", 32'(duty), 32'd0);
        for (int c = 0; c < 26; c++) cyc(4'b0001);
        chk("repeat_duty", 32'(duty), 32'd9);

        // Asynchronous reset in the middle of a repeat run, key still held.
        @(negedge clk);
        n_reset = 1'b0;
        #1;
        model_reset();
        chk("async_rst_duty",    32'(duty),    32'(DUTY_INIT));
        chk("async_rst_enable",  32'(enable),  32'd1);
        chk("async_rst_pwm_out", 32'(pwm_out), 32'd0);
        chk("async_rst_key_evt", 32'(key_evt), 32'd0);
        @(posedge clk);
        #2 n_reset = 1'b1;
        cyc(4'b0001);
        chk("post_rst_duty", 32'(duty),    32'd8);
        chk("post_rst_evt",  32'(key_evt), 32'd1);
        cyc(4'b0000);

        for (int b = 0; b < 60; b++) begin
            logic [3:0] p;
            int         r, n;
            r = $urandom_range(0, 9);
            case (r)
                0, 1:    p = 4'b0001;
                2, 3:    p = 4'b0010;
                4:       p = 4'b0011;
                5:       p = 4'b0000;
                6:       p = 4'b1000;
                7:       p = 4'b0100;
                default: p = 4'($urandom_range(0, 15));
            endcase
            n = $urandom_range(1, 40);
            for (int c = 0; c < n; c++) cyc(p);
            if (r == 9) for (int c = 0; c < 4; c++) cyc(~p & 4'b0011);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
